// File: rtl/map_tile_arbiter.sv
// Map tile arbiter: fetches a level map from ROM into a local register and
// serves tile wall queries from two requesters with round-robin arbitration.
module map_tile_arbiter #(
    parameter int unsigned COLS    = 30,
    parameter int unsigned ROWS    = 20,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             level_in,
    input  logic                   level_load,
    output logic [9:0]             rom_level,
    input  logic [COLS*ROWS-1:0]   rom_map,
    output logic                   map_valid,
    input  logic                   req0,
    input  logic [4:0]             col0,
    input  logic [4:0]             row0,
    input  logic                   req1,
    input  logic [4:0]             col1,
    input  logic [4:0]             row1,
    output logic                   ack0,
    output logic                   wall0,
    output logic                   ack1,
    output logic                   wall1
);

    localparam int unsigned MAP_W = COLS * ROWS;
    localparam int unsigned IDX_W = ($clog2(MAP_W) > 10) ? $clog2(MAP_W) : 10;
    localparam int unsigned CNT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [MAP_W-1:0]   map_q;
    logic               prio1;

    logic can_grant;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic tile0;
    logic tile1;

    // Out-of-bounds coordinates read as wall; row 0 / col 0 sits in the MSB.
    function automatic logic tile_wall(input logic [MAP_W-1:0] m,
                                       input logic [4:0] col,
                                       input logic [4:0] row);
        logic [IDX_W-1:0] idx;
        logic             bit_v;
        idx = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
        if ((32'(col) >= COLS) || (32'(row) >= ROWS)) begin
            bit_v = 1'b1;
        end else begin
            bit_v = m[IDX_W'(MAP_W - 1) - idx];
        end
        return bit_v;
    endfunction

    // A held request is masked for the cycle its ack is high.
    always_comb begin
        can_grant = (state == SERVE) && !level_load;
        elig0     = req0 && !ack0;
        elig1     = req1 && !ack1;
        grant0    = can_grant && elig0 && (!elig1 || !prio1);
        grant1    = can_grant && elig1 && (!elig0 || prio1);
        tile0     = tile_wall(map_q, col0, row0);
        tile1     = tile_wall(map_q, col1, row1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            cnt       <= '0;
            map_q     <= '0;
            map_valid <= 1'b0;
            rom_level <= '0;
            prio1     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            wall0     <= 1'b0;
            wall1     <= 1'b0;
        end else begin
            ack0  <= grant0;
            ack1  <= grant1;
            wall0 <= grant0 && tile0;
            wall1 <= grant1 && tile1;
            if (grant0) begin
                prio1 <= 1'b1;
            end else if (grant1) begin
                prio1 <= 1'b0;
            end

            if (level_load) begin
                rom_level <= level_in;
                map_valid <= 1'b0;
                cnt       <= '0;
                state     <= FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        // ROM word is stable ROM_LAT cycles after the address edge.
                        if (cnt == CNT_W'(ROM_LAT)) begin
                            map_q     <= rom_map;
                            map_valid <= 1'b1;
                            state     <= SERVE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// Directed bench for map_tile_arbiter with a ROM model and an ack scoreboard.
module tb_map_tile_arbiter;

    localparam int unsigned COLS  = 30;
    localparam int unsigned ROWS  = 20;
    localparam int unsigned MAP_W = COLS * ROWS;

    logic              clk;
    logic              rst;
    logic [9:0]        level_in;
    logic              level_load;
    logic [9:0]        rom_level;
    logic [MAP_W-1:0]  rom_map;
    logic [MAP_W-1:0]  rom_q;
    logic              noise;
    logic              map_valid;
    logic              req0, req1;
    logic [4:0]        col0, row0, col1, row1;
    logic              ack0, ack1, wall0, wall1;

    typedef struct {
        int   port;
        logic wall;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    map_tile_arbiter #(.COLS(COLS), .ROWS(ROWS), .ROM_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .level_in   (level_in),
        .level_load (level_load),
        .rom_level  (rom_level),
        .rom_map    (rom_map),
        .map_valid  (map_valid),
        .req0       (req0),
        .col0       (col0),
        .row0       (row0),
        .req1       (req1),
        .col1       (col1),
        .row1       (row1),
        .ack0       (ack0),
        .wall0      (wall0),
        .ack1       (ack1),
        .wall1      (wall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a background pattern plus pinned tiles used by the tests.
    function automatic logic [MAP_W-1:0] rom_word(input int lvl);
        logic [MAP_W-1:0] w;
        for (int i = 0; i < MAP_W; i++) w[i] = (((i * 7) + (lvl * 11)) % 3) == 0;
        if (lvl == 3) begin
            w[534] = 1'b1;   // row 2, col 5
            w[565] = 1'b0;   // row 1, col 4
            w[569] = 1'b0;   // row 1, col 0 (aliased by col 30 row 0)
        end
        if (lvl == 7) w[565] = 1'b1;
        return w;
    endfunction

    function automatic logic model_wall(input int lvl, input int col, input int row);
        logic [MAP_W-1:0] w;
        if (col >= COLS || row >= ROWS) return 1'b1;
        w = rom_word(lvl);
        return w[MAP_W - 1 - (row * COLS + col)];
    endfunction

    // One-cycle ROM latency; noise corrupts the bus outside the latch edge.
    always @(posedge clk) rom_q <= rom_word(int'(rom_level));
    assign rom_map = rom_q ^ {MAP_W{noise}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int port, input logic wall);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_ack observed=port%0d@%0d expected=none", port, cyc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ack_port", 64'(port), 64'(e.port));
            check("ack_wall", 64'(wall), 64'(e.wall));
            check("ack_cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    function automatic void push(input int port, input logic wall, input int at);
        exp_t e;
        e.port = port;
        e.wall = wall;
        e.cyc  = at;
        sb.push_back(e);
    endfunction

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            check("single_grant", 64'(ack0 & ack1), 64'd0);
            check("wall0_idle", 64'(wall0 & ~ack0), 64'd0);
            check("wall1_idle", 64'(wall1 & ~ack1), 64'd0);
            if (ack0 === 1'b1) pop_check(0, wall0);
            if (ack1 === 1'b1) pop_check(1, wall1);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1; noise = 1'b0;
        level_in = '0; level_load = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        col0 = '0; row0 = '0; col1 = '0; row1 = '0;
        step(); step();
        rst = 1'b0;
        check("rst_rom_level", 64'(rom_level), 64'd0);
        check("rst_map_valid", 64'(map_valid), 64'd0);
        check("rst_acks", 64'({ack0, ack1, wall0, wall1}), 64'd0);
        check("rst_state", 64'(dut.state), 64'd0);
        check("rst_map_zero", 64'(dut.map_q === '0), 64'd1);

        // Load level 3
        level_in = 10'd3; level_load = 1'b1;
        step();
        level_load = 1'b0;
        check("load_rom_level", 64'(rom_level), 64'd3);
        check("load_valid_e0", 64'(map_valid), 64'd0);
        step();
        check("load_valid_e1", 64'(map_valid), 64'd0);
        step();
        check("load_valid_e2", 64'(map_valid), 64'd1);
        check("load_map_word", 64'(dut.map_q === rom_word(3)), 64'd1);
        noise = 1'b1;
        step();
        check("rom_ignored", 64'(dut.map_q === rom_word(3)), 64'd1);
        noise = 1'b0;

        // Contention from reset pointer: 0,1,0,1
        col0 = 5'd5; row0 = 5'd2; col1 = 5'd4; row1 = 5'd1;
        req0 = 1'b1; req1 = 1'b1;
        e = cyc + 1;
        push(0, model_wall(3, 5, 2), e);
        push(1, model_wall(3, 4, 1), e + 1);
        push(0, model_wall(3, 5, 2), e + 2);
        push(1, model_wall(3, 4, 1), e + 3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_ack0", 64'(ack0), 64'(i % 2 == 0));
            check("rr_ack1", 64'(ack1), 64'(i % 2 == 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Single held query: one ack, not repeated next cycle
        col0 = 5'd5; row0 = 5'd2; req0 = 1'b1;
        push(0, 1'b1, cyc + 1);
        step();
        check("single_ack0", 64'(ack0), 64'd1);
        check("single_wall0", 64'(wall0), 64'd1);
        step();
        check("single_no_repeat", 64'(ack0), 64'd0);
        req0 = 1'b0;
        step();

        // Bounds: both out of range read as wall; pointer now favours 1
        col0 = 5'd30; row0 = 5'd0; col1 = 5'd0; row1 = 5'd20;
        req0 = 1'b1; req1 = 1'b1;
        e = cyc + 1;
        push(1, 1'b1, e);
        push(0, 1'b1, e + 1);
        step();
        check("oob_row_wall1", 64'(wall1), 64'd1);
        step();
        check("oob_col_wall0", 64'(wall0), 64'd1);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Reload race with req1
        col1 = 5'd4; row1 = 5'd1;
        level_in = 10'd7; level_load = 1'b1; req1 = 1'b1;
        e = cyc + 1;
        step();
        level_load = 1'b0;
        check("race_no_ack_l", 64'(ack1), 64'd0);
        check("race_rom_level", 64'(rom_level), 64'd7);
        check("race_valid_low", 64'(map_valid), 64'd0);
        step();
        check("race_no_ack_l1", 64'(ack1), 64'd0);
        step();
        check("race_valid_high", 64'(map_valid), 64'd1);
        check("race_no_ack_l2", 64'(ack1), 64'd0);
        push(1, model_wall(7, 4, 1), e + 3);
        step();
        check("race_ack1", 64'(ack1), 64'd1);
        check("race_wall1_new", 64'(wall1), 64'd1);
        req1 = 1'b0;
        step();

        // Reset one cycle after a load
        col0 = 5'd5; row0 = 5'd2; req0 = 1'b1;
        level_in = 10'd3; level_load = 1'b1;
        step();
        level_load = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_state", 64'(dut.state), 64'd0);
        check("abort_valid", 64'(map_valid), 64'd0);
        check("abort_acks", 64'({ack0, ack1}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_valid_hold", 64'(map_valid), 64'd0);
            check("abort_ack_hold", 64'({ack0, ack1}), 64'd0);
        end
        req0 = 1'b0;
        step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_tile_arbiter.md
MAP_TILE_ARBITER -- requirements
Module: map_tile_arbiter

Interface
REQ-001 Parameters SHALL be: COLS, 30, tiles per row; ROWS, 20, rows per map; ROM_LAT, 1, clock cycles from rom_level change to rom_map valid.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 level_in  input  10  level number to load.
REQ-005 level_load  input  1  one-cycle pulse; start loading level_in.
REQ-006 rom_level  output  10  level address to the map ROM.
REQ-007 rom_map  input  600  map word from the ROM; bit 599 = tile (row 0, col 0); 1 = wall.
REQ-008 map_valid  output  1  high while a loaded map is being served.
REQ-009 req0 / req1  input  1  tile query request, requester 0 / 1.
REQ-010 col0, row0 / col1, row1  input  5 each  tile coordinates of each query.
REQ-011 ack0 / ack1  output  1  one-cycle acknowledge per requester.
REQ-012 wall0 / wall1  output  1  query result, valid while the matching ack is high.

Function
REQ-013 The FSM SHALL have states EMPTY, FETCH and SERVE.
REQ-014 level_load in any state SHALL register level_in into rom_level, clear map_valid, clear the wait counter and enter FETCH.
REQ-015 FETCH SHALL count ROM_LAT+1 cycles after the load edge; on the final count edge, rom_map SHALL be latched into an internal 600-bit map register, map_valid set and SERVE entered.
REQ-016 With ROM_LAT=1, map_valid SHALL rise at the 2nd rising edge after the edge sampling level_load.
REQ-017 Queries SHALL be granted only in SERVE, at most one grant per cycle.
REQ-018 A requester SHALL be eligible when its req is high and its ack is low, so a held req is not served twice in consecutive cycles.
REQ-019 When exactly one requester is eligible, it SHALL be granted.
REQ-020 When both are eligible, the grant SHALL go to the requester not granted most recently (round-robin pointer); after reset the pointer SHALL favour requester 0.
REQ-021 A grant sampled at edge k SHALL drive ackN high and wallN valid for exactly the cycle after edge k (registered, latency 1).
REQ-022 wallN SHALL equal map bit 599 - (row*COLS + col), with the index computed at 10 bits minimum and no truncation.
REQ-023 For col >= COLS or row >= ROWS, wallN SHALL be 1 (out of bounds reads as wall).
REQ-024 A level_load in the same cycle as an eligible request SHALL take precedence: no grant that cycle, and no ack until the new map is valid.
REQ-025 A requester holding req across a reload SHALL be served from the new map only; ack/wall SHALL never reflect a partially loaded map.
REQ-026 ackN and wallN SHALL be 0 whenever no grant occurred in the previous edge.
REQ-027 rom_map SHALL be sampled only on the latch edge; changes at other times SHALL have no effect.

Reset
REQ-028 On rst high at a rising edge, the following SHALL be set: state EMPTY, rom_level 0, map register all-zero, map_valid 0, ack0/ack1 0, wall0/wall1 0, wait counter 0, pointer favouring requester 0.
REQ-029 rst SHALL override level_load and requests in the same cycle.
REQ-030 rst asserted during FETCH or SERVE SHALL abort the operation without a latch or ack in the following cycle.

Verification
REQ-031 Load: rst, then level_load with level_in=3 -> rom_level=3 after 1 edge; map_valid=1 two edges later; map register equals ROM word 3.
REQ-032 Single query: map bit for (row 2, col 5) = 1; req0 held with col0=5, row0=2 -> ack0=1 and wall0=1 for one cycle, one cycle after the grant; no second ack0 the following cycle.
REQ-033 Contention: req0 and req1 held continuously -> acks alternate 0,1,0,1 starting with requester 0; each ack is 1 cycle wide.
REQ-034 Bounds: query with col=30, row=0, and a query with col=0, row=20 -> wall=1 regardless of map contents.
REQ-035 Reload race: level_load with level_in=7 in the same cycle as req1 -> no ack1 until map_valid re-rises; ack1 then returns the level-7 bit.
REQ-036 Reset mid-fetch: rst one cycle after level_load -> map_valid stays 0, acks stay 0, state EMPTY.
